// File: rtl/gmii_rx_pkg.sv
// Shared definitions for the GMII receive path: FSM states, CRC-32 constants
// and the default legal frame-length window.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [7:0] SFD = 8'hD5;
    localparam logic [7:0] PRE = 8'h55;

    localparam int MIN_LEN_DEF = 64;
    localparam int MAX_LEN_DEF = 1518;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32; purely combinational so the
// TX FCS generator can reuse it unchanged.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // NOTE: c is assigned before the loop reads it, so every path drives it and no latch is inferred.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC, length and
// rx_er, and reports per-frame status plus good/bad frame statistics.
module gmii_rx_framer
    import gmii_rx_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_d,
    input  logic        clear,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [15:0] frame_len,
    output logic [23:0] good_cnt,
    output logic [23:0] bad_cnt
);

    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
    localparam logic [15:0] FCS_LEN = 16'd4;

    rx_state_t       state;
    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic [3:0][7:0] dly;
    logic [15:0]     byte_cnt;
    logic            er_seen;

    logic            short_frame;
    logic            len_bad;
    logic            drop_end;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (rx_d),
        .crc_out (crc_next)
    );

    // byte_cnt holds the full post-SFD total when rx_dv falls in DATA.
    assign short_frame = (byte_cnt <= FCS_LEN);
    assign len_bad     = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
    assign drop_end    = (state == DROP) && !rx_dv;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc       <= '0;
            // NOTE: the delay line is reset too, so nothing stale can leak out after a mid-frame reset.
            dly       <= '0;
            byte_cnt  <= '0;
            er_seen   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            frame_len <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        state <= (rx_d == PRE) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end else if (rx_d == SFD) begin
                        state    <= DATA;
                        crc      <= CRC_INIT;
                        byte_cnt <= '0;
                        er_seen  <= 1'b0;
                    end else if (rx_d != PRE) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        crc <= crc_next;
                        dly <= {dly[2:0], rx_d};
                        if (byte_cnt != 16'hFFFF) begin
                            byte_cnt <= byte_cnt + 16'd1;
                        end
                        if (rx_er) begin
                            er_seen <= 1'b1;
                        end
                        // Emitting only once four bytes are buffered keeps the FCS off the output.
                        if (byte_cnt >= FCS_LEN) begin
                            out_valid <= 1'b1;
                            out_data  <= dly[3];
                            out_sof   <= (byte_cnt == FCS_LEN);
                        end
                    end else begin
                        state     <= IDLE;
                        out_eof   <= 1'b1;
                        out_err   <= (crc != CRC_RESIDUE) || er_seen || rx_er || len_bad || short_frame;
                        frame_len <= short_frame ? 16'd0 : (byte_cnt - FCS_LEN);
                    end
                end
                DROP: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counting from the registered strobe lets a coincident clear win cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (clear) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (out_eof && !out_err) begin
                good_cnt <= good_cnt + 24'd1;
            end
            if ((out_eof && out_err) || drop_end) begin
                bad_cnt <= bad_cnt + 24'd1;
            end
        end
    end

endmodule

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 Parameter MIN_LEN, default 64, is the minimum legal frame length in bytes, counted from DA through FCS inclusive.
REQ-002 Parameter MAX_LEN, default 1518, is the maximum legal frame length in bytes, counted from DA through FCS inclusive.
REQ-003 clk  in  1  is the 125 MHz GMII receive clock and the only clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  is the asynchronous, active-low reset.
REQ-005 rx_dv  in  1  is GMII receive data valid.
REQ-006 rx_er  in  1  is GMII receive error.
REQ-007 rx_d  in  8  is GMII receive data.
REQ-008 clear  in  1  is a synchronous clear of the statistics counters.
REQ-009 out_valid  out  1  qualifies out_data as one payload byte.
REQ-010 out_data  out  8  is a frame byte, DA through the last byte before the FCS.
REQ-011 out_sof  out  1  marks the first out_valid byte of a frame.
REQ-012 out_eof  out  1  is a one-cycle frame-status strobe, always asserted with out_valid low.
REQ-013 out_err  out  1  is the frame-bad flag and is valid only while out_eof is high.
REQ-014 frame_len  out  16  is the payload byte count, excluding the FCS, and is valid while out_eof is high.
REQ-015 good_cnt  out  24  counts good frames.
REQ-016 bad_cnt  out  24  counts bad or dropped frames.

Function
REQ-017 The FSM SHALL have the states IDLE, PREAMBLE, DATA and DROP.
REQ-018 In IDLE: rx_dv=1 with rx_d=0x55 goes to PREAMBLE; rx_dv=1 with any other byte goes to DROP.
REQ-019 In PREAMBLE: 0x55 stays; 0xD5 goes to DATA; any other byte goes to DROP; rx_dv=0 returns to IDLE with no status and no count.
REQ-020 In DATA: every byte with rx_dv=1 is fed to the CRC and the 4-byte delay line.
REQ-021 In DATA, rx_dv=0 SHALL return the FSM to IDLE and issue out_eof on the next cycle.
REQ-022 In DROP: the FSM waits for rx_dv=0, then returns to IDLE, increments bad_cnt and issues no out_eof.
REQ-023 Post-SFD byte k SHALL be driven on out_data with out_valid=1 in the cycle after post-SFD byte k+4 is sampled, so the 4 FCS bytes are never output.
REQ-024 out_sof SHALL be high together with the first out_valid of a frame and low otherwise.
REQ-025 The CRC SHALL be CRC-32, reflected LSB-first, polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD, run over all post-SFD bytes including the FCS.
REQ-026 The CRC passes when the final register value equals the residue 0xDEBB20E3.
REQ-027 out_err=1 SHALL be asserted if the CRC fails, OR rx_er was sampled high at any point in DATA, OR the post-SFD byte total is < MIN_LEN or > MAX_LEN.
REQ-028 frame_len SHALL equal the post-SFD byte total minus 4, floored at 0.
REQ-029 The internal byte counter SHALL saturate at 0xFFFF rather than wrap.
REQ-030 A frame with 4 or fewer post-SFD bytes SHALL produce no out_valid, and SHALL produce out_eof with out_err=1 and frame_len=0.
REQ-031 On out_eof, good_cnt increments if out_err=0, else bad_cnt increments; both counters wrap modulo 2^24.
REQ-032 clear=1 SHALL zero both counters on the next edge and takes priority over a coincident increment.
REQ-033 Back-to-back frames with a 1-cycle rx_dv gap SHALL be handled: out_eof of frame N may coincide with PREAMBLE of frame N+1.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 rst_n=0 SHALL immediately force the FSM to IDLE and clear the delay line and CRC.
REQ-036 rst_n=0 SHALL immediately force out_valid, out_sof, out_eof, out_err, out_data, frame_len, good_cnt and bad_cnt to 0.
REQ-037 Reset released mid-frame (rx_dv=1 carrying a non-0x55 byte) SHALL go to DROP and count one bad frame at rx_dv fall.

Structure
REQ-038 A shared package gmii_rx_pkg SHALL hold the state enum, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3, SFD=0xD5, PRE=0x55, and the MIN_LEN/MAX_LEN defaults.
REQ-039 One combinational sub-module crc32_d8 SHALL compute the next CRC from the current CRC and one data byte; it is shared with the future TX FCS generator.
REQ-040 The total implementation SHALL be roughly 150-300 lines of RTL.

Verification
REQ-041 The bench SHALL drive 7x0x55, 0xD5, a 60-byte payload and a correct FCS -> 60 out_valid bytes matching the payload, out_sof on byte 0, out_eof with out_err=0 and frame_len=60, good_cnt=1.
REQ-042 The bench SHALL repeat REQ-041 with FCS byte 0 XOR 0x01 -> 60 bytes output, out_err=1, bad_cnt=1, good_cnt unchanged.
REQ-043 The bench SHALL drive a 64-byte legal frame with rx_er pulsed for 1 cycle at payload byte 20 -> out_err=1, frame_len=60.
REQ-044 The bench SHALL drive 3x0x55, 0x12, 10 bytes -> DROP, no out_valid, no out_eof, bad_cnt +1; then a legal 1518-byte frame -> good, frame_len=1514; then a 1519-byte frame -> out_err=1.
REQ-045 The bench SHALL send two legal frames separated by a 1-cycle rx_dv gap while asserting clear on the cycle of the first out_eof -> good_cnt=0 after the first frame and 1 after the second.
REQ-046 The bench SHALL assert rst_n=0 at payload byte 30 of a frame -> all outputs 0 that cycle, no out_eof; after release the remainder is dropped with bad_cnt=1.
